// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and one-entry instruction slot feeding decode over valid/ready
module fetch_unit #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int PROG_LEN = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic [AW-1:0] o_rom_addr,
    input  logic [DW-1:0] i_rom_instr,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_instr,
    output logic [AW-1:0] o_out_pc,
    input  logic          i_jmp_en,
    input  logic [AW-1:0] i_jmp_addr,
    output logic          o_busy,
    output logic          o_done,
    output logic [7:0]    o_fetch_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [AW-1:0] LAST = AW'(PROG_LEN - 1);
    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic          r_valid;
    logic [DW-1:0] r_instr;
    logic [AW-1:0] r_out_pc;
    logic [7:0]    r_cnt;
    logic          w_start;
    logic          w_jmp;
    logic          w_fetch;
    logic          w_jmp_in_prog;
    // start and jump qualification; start outranks a same-cycle jump
    always_comb begin
        w_start       = i_start && r_state != RUN;
        w_jmp         = i_jmp_en && r_state != IDLE;
        w_fetch       = r_state == RUN && (!r_valid || i_out_ready) && !i_jmp_en;
        w_jmp_in_prog = 32'(i_jmp_addr) < PROG_LEN;
    end
    // control state, PC, slot and fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_out_pc <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (w_jmp) begin
            r_pc    <= i_jmp_addr;
            r_valid <= 1'b0;
            r_state <= w_jmp_in_prog ? RUN : DONE;
        end else if (w_fetch) begin
            r_instr  <= i_rom_instr;
            r_out_pc <= r_pc;
            r_valid  <= 1'b1;
            r_cnt    <= r_cnt != 8'hFF ? r_cnt + 8'd1 : r_cnt;
            r_pc     <= r_pc == LAST ? r_pc : r_pc + 1'b1;
            r_state  <= r_pc == LAST ? DONE : RUN;
        end else if (r_valid && i_out_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign o_rom_addr  = r_pc;
    assign o_out_valid = r_valid;
    assign o_out_instr = r_instr;
    assign o_out_pc    = r_out_pc;
    assign o_fetch_cnt = r_cnt;
    assign o_done      = r_state == DONE && !r_valid;
    assign o_busy      = r_state != IDLE && !o_done;
endmodule
